// File: rtl/fetch_ctrl.sv
// Fetch sequencer for the IF/ID stage: owns the PC, drives the instruction-memory
// handshake, holds one fetched instruction for decode and flags fetch faults.
module fetch_ctrl #(
    parameter logic [31:0] RESET   = 32'h0000_0000,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_mem_req,
    output logic [31:0] inst_mem_address,
    input  logic        inst_mem_is_valid,
    input  logic [31:0] inst_mem_read_data,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [31:0] inst_fetch_pc,
    output logic        stall_read,
    output logic        exception
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        FAULT
    } state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic [31:0]   r_pc;
    logic          r_instValid;
    logic [31:0]   r_instruction;
    logic [31:0]   r_instFetchPc;
    logic [TW-1:0] r_timer;

    logic w_req;
    logic w_fill;
    logic w_consume;
    logic w_wait;
    logic w_timeoutHit;
    logic w_badRedirect;

    assign w_fill        = w_req & inst_mem_is_valid & ~redirect;
    assign w_consume     = r_instValid & ~stall;
    assign w_wait        = w_req & ~inst_mem_is_valid;
    // Fault on the edge that closes the TIMEOUT-th consecutive waiting cycle.
    assign w_timeoutHit  = w_wait & ~redirect & (r_timer == TW'(TIMEOUT - 1));
    assign w_badRedirect = redirect & (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            BOOT: begin
                if ((RESET[1:0] != 2'b00) || w_badRedirect) begin
                    w_stateNext = FAULT;
                end else begin
                    w_stateNext = FETCH;
                end
            end
            FETCH: begin
                if (w_badRedirect || w_timeoutHit) begin
                    w_stateNext = FAULT;
                end
            end
            FAULT: begin
                w_stateNext = FAULT;
            end
            default: begin
                w_stateNext = BOOT;
            end
        endcase
    end

    always_comb begin
        w_req = 1'b0;
        if (r_state == FETCH) begin
            w_req = ~r_instValid | ~stall;
        end
    end

    // Redirect outranks fill, consume and stall; a fault freezes everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET;
            r_instValid   <= 1'b0;
            r_instruction <= 32'h0000_0013;
            r_instFetchPc <= RESET;
            r_timer       <= '0;
        end else if ((r_state == FAULT) || (w_stateNext == FAULT)) begin
            r_instValid <= 1'b0;
            r_timer     <= '0;
        end else if (redirect) begin
            r_pc        <= redirect_pc;
            r_instValid <= 1'b0;
            r_timer     <= '0;
        end else if (w_fill) begin
            r_instruction <= inst_mem_read_data;
            r_instFetchPc <= r_pc;
            r_instValid   <= 1'b1;
            r_pc          <= r_pc + 32'd4;
            r_timer       <= '0;
        end else begin
            if (w_consume) begin
                r_instValid <= 1'b0;
            end
            r_timer <= w_wait ? (r_timer + 1'b1) : '0;
        end
    end

    assign inst_mem_req     = w_req;
    assign inst_mem_address = r_pc;
    assign inst_valid       = r_instValid;
    assign instruction      = r_instruction;
    assign inst_fetch_pc    = r_instFetchPc;
    assign exception        = (r_state == FAULT);
    assign stall_read       = ~r_instValid | stall | (r_state == FAULT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl: normal streaming, stalls, redirects,
// PC wrap, memory timeout boundary, misaligned redirect and asynchronous reset.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_mem_req;
    logic [31:0] inst_mem_address;
    logic        inst_mem_is_valid;
    logic [31:0] inst_mem_read_data;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] inst_fetch_pc;
    logic        stall_read;
    logic        exception;

    int numChecks = 0;
    int numFails  = 0;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        memValid;
        logic [31:0] memData;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expInstr;
        logic [31:0] expPc;
        logic        expStallRead;
    } vec_t;

    vec_t vecs[16];

    fetch_ctrl #(
        .RESET   (32'h0000_0000),
        .TIMEOUT (16)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .stall              (stall),
        .redirect           (redirect),
        .redirect_pc        (redirect_pc),
        .inst_mem_req       (inst_mem_req),
        .inst_mem_address   (inst_mem_address),
        .inst_mem_is_valid  (inst_mem_is_valid),
        .inst_mem_read_data (inst_mem_read_data),
        .inst_valid         (inst_valid),
        .instruction        (instruction),
        .inst_fetch_pc      (inst_fetch_pc),
        .stall_read         (stall_read),
        .exception          (exception)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc,
                                 input logic v, input logic [31:0] d);
        stall              = s;
        redirect           = r;
        redirect_pc        = rpc;
        inst_mem_is_valid  = v;
        inst_mem_read_data = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        stepCycle();
        reset = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " req"},        32'(inst_mem_req),  32'h0);
        checkOutput({tag, " addr"},       inst_mem_address,   32'h0);
        checkOutput({tag, " inst_valid"}, 32'(inst_valid),    32'h0);
        checkOutput({tag, " instr"},      instruction,        32'h0000_0013);
        checkOutput({tag, " fetch_pc"},   inst_fetch_pc,      32'h0);
        checkOutput({tag, " stall_read"}, 32'(stall_read),    32'h1);
        checkOutput({tag, " exception"},  32'(exception),     32'h0);
    endtask

    initial begin
        // stall redir rpc memValid memData | req addr valid instr fetchPc stallRead
        vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hDEAD_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_0000, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_0004, 1'b1, 32'h0000_0004, 1'b1, 32'h1111_0000, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hDEAD_0008, 1'b0, 32'h0000_0008, 1'b1, 32'h1111_0004, 32'h0000_0004, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hDEAD_0008, 1'b0, 32'h0000_0008, 1'b1, 32'h1111_0004, 32'h0000_0004, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hDEAD_0008, 1'b0, 32'h0000_0008, 1'b1, 32'h1111_0004, 32'h0000_0004, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_0008, 1'b1, 32'h0000_0008, 1'b1, 32'h1111_0004, 32'h0000_0004, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'hBAD0_000C, 1'b0, 32'h0000_000C, 1'b1, 32'h1111_0008, 32'h0000_0008, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h2222_0100, 1'b1, 32'h0000_0100, 1'b0, 32'h1111_0008, 32'h0000_0008, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_0200, 1'b1, 32'hBAD0_0104, 1'b1, 32'h0000_0104, 1'b1, 32'h2222_0100, 32'h0000_0100, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'hBAD0_0200, 1'b1, 32'h0000_0200, 1'b0, 32'h2222_0100, 32'h0000_0100, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h3333_0200, 1'b1, 32'h0000_0200, 1'b0, 32'h2222_0100, 32'h0000_0100, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h3333_0204, 1'b1, 32'h0000_0204, 1'b1, 32'h3333_0200, 32'h0000_0200, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hBAD0_0208, 1'b1, 32'h0000_0208, 1'b1, 32'h3333_0204, 32'h0000_0204, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h4444_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h3333_0204, 32'h0000_0204, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'hBAD0_0000, 1'b1, 32'h0000_0000, 1'b1, 32'h4444_FFFC, 32'hFFFF_FFFC, 1'b0};

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        checkResetValues("reset");
        stepCycle();
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].stall, vecs[i].redirect, vecs[i].rpc,
                          vecs[i].memValid, vecs[i].memData);
            #2;
            checkOutput($sformatf("vec%0d req", i),        32'(inst_mem_req), 32'(vecs[i].expReq));
            checkOutput($sformatf("vec%0d addr", i),       inst_mem_address,  vecs[i].expAddr);
            checkOutput($sformatf("vec%0d inst_valid", i), 32'(inst_valid),   32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d instr", i),      instruction,       vecs[i].expInstr);
            checkOutput($sformatf("vec%0d fetch_pc", i),   inst_fetch_pc,     vecs[i].expPc);
            checkOutput($sformatf("vec%0d stall_read", i), 32'(stall_read),   32'(vecs[i].expStallRead));
            checkOutput($sformatf("vec%0d exception", i),  32'(exception),    32'h0);
            stepCycle();
        end

        // Response withheld 15 cycles then delivered: no fault.
        doReset();
        stepCycle();
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            #2;
            checkOutput($sformatf("wait15 cyc%0d req", i), 32'(inst_mem_req), 32'h1);
            checkOutput($sformatf("wait15 cyc%0d exc", i), 32'(exception),    32'h0);
            stepCycle();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h5555_0000);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("wait15 exc",        32'(exception),   32'h0);
        checkOutput("wait15 inst_valid", 32'(inst_valid),  32'h1);
        checkOutput("wait15 instr",      instruction,      32'h5555_0000);
        checkOutput("wait15 addr",       inst_mem_address, 32'h0000_0004);
        checkOutput("midreq req before", 32'(inst_mem_req), 32'h1);
        reset = 1'b1;
        #1;
        checkResetValues("midreq reset");
        stepCycle();
        reset = 1'b0;

        // Response withheld 16 cycles: timeout fault, sticky through redirect.
        stepCycle();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            #2;
            checkOutput($sformatf("wait16 cyc%0d exc", i), 32'(exception), 32'h0);
            stepCycle();
        end
        #1;
        checkOutput("timeout exc",        32'(exception),  32'h1);
        checkOutput("timeout req",        32'(inst_mem_req), 32'h0);
        checkOutput("timeout stall_read", 32'(stall_read), 32'h1);
        checkOutput("timeout inst_valid", 32'(inst_valid), 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'h6666_0000);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h6666_0000);
        stepCycle();
        checkOutput("fault sticky exc",   32'(exception),    32'h1);
        checkOutput("fault sticky req",   32'(inst_mem_req), 32'h0);
        checkOutput("fault sticky valid", 32'(inst_valid),   32'h0);
        checkOutput("fault sticky addr",  inst_mem_address,  32'h0);

        // Misaligned redirect target faults on the next cycle.
        doReset();
        stepCycle();
        applyStimulus(1'b0, 1'b1, 32'h0000_0102, 1'b0, 32'h0);
        #2;
        checkOutput("misalign pre exc", 32'(exception), 32'h0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h7777_0000);
        #2;
        checkOutput("misalign exc",        32'(exception),    32'h1);
        checkOutput("misalign stall_read", 32'(stall_read),   32'h1);
        checkOutput("misalign req",        32'(inst_mem_req), 32'h0);
        reset = 1'b1;
        #1;
        checkResetValues("post-fault reset");
        stepCycle();
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
